// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, metadata field positions, FSM states and victim choice for cache_fill_ctrl
package cache_pkg;
    localparam int TAG_W = 8;
    localparam int IDX_W = 4;
    localparam int WORDS = 8;
    localparam int CNT_W = $clog2(WORDS);
    localparam int META_W = TAG_W + 2;
    localparam int META_V = TAG_W + 1;
    localparam int META_LRU = TAG_W;
    localparam int META_TAG_HI = TAG_W - 1;
    typedef enum logic [1:0] {IDLE, FILL, META} state_t;
    // Invalid ways are refilled first; among valid ways the lru=1 way goes, ties go to way 0
    function automatic logic pick_victim(logic [META_W-1:0] m0, logic [META_W-1:0] m1);
        return !m0[META_V] ? 1'b0 : !m1[META_V] ? 1'b1 : (m0[META_LRU] != m1[META_LRU]) && m1[META_LRU];
    endfunction
endpackage

// File: rtl/cache_way_cmp.sv
// cache_way_cmp: valid-qualified tag compare for one way
module cache_way_cmp
    import cache_pkg::*;
(
    input  logic [META_W-1:0] meta,
    input  logic [TAG_W-1:0]  tag,
    output logic              match
);
    logic unused_lru;
    assign unused_lru = meta[META_LRU];
    assign match = meta[META_V] && (meta[META_TAG_HI:0] == tag);
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: 2-way hit/LRU update and 8-word miss fill; CACHE_PERF_CNT_EN adds hit_cnt/miss_cnt
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [15:0]       req_addr,
    input  logic [META_W-1:0] meta0,
    input  logic [META_W-1:0] meta1,
    output logic              hit,
    output logic              hit_way,
    output logic              stall,
    output logic              mem_rd_en,
    output logic [15:0]       mem_addr,
    input  logic              mem_data_valid,
    output logic              data_wr_en,
    output logic              data_wr_way,
    output logic [CNT_W-1:0]  data_wr_word,
    output logic [1:0]        meta_wr_en,
    output logic [META_W-1:0] meta_wr_data0,
    output logic [META_W-1:0] meta_wr_data1
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    state_t state, state_nx;
    logic m0, m1, miss, victim, victim_q, issue_done;
    logic [CNT_W-1:0] issue_cnt, recv_cnt;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W:0] other_q;
    logic unused_addr;
    assign unused_addr = ^req_addr[3:0];
    cache_way_cmp u_cmp0 (.meta(meta0), .tag(req_addr[15:8]), .match(m0));
    cache_way_cmp u_cmp1 (.meta(meta1), .tag(req_addr[15:8]), .match(m1));
    always_comb begin
        hit = (state == IDLE) && req_valid && (m0 || m1);
        hit_way = hit && !m0;
        miss = (state == IDLE) && req_valid && !(m0 || m1);
        victim = pick_victim(meta0, meta1);
        stall = miss || (state != IDLE);
        mem_rd_en = (state == FILL) && !issue_done;
        mem_addr = mem_rd_en ? {tag_q, idx_q, issue_cnt, 1'b0} : '0;
        data_wr_en = (state == FILL) && mem_data_valid;
        data_wr_way = (state == FILL) && victim_q;
        data_wr_word = recv_cnt;
        meta_wr_en = {2{hit || (state == META)}};
        // The non-victim way keeps valid/tag captured at miss time, so a dropped request cannot corrupt it
        meta_wr_data0 = (state == META) ? (victim_q ? {other_q[TAG_W], 1'b1, other_q[TAG_W-1:0]} : {2'b10, tag_q})
                      : hit ? {meta0[META_V], hit_way, meta0[META_TAG_HI:0]} : '0;
        meta_wr_data1 = (state == META) ? (victim_q ? {2'b10, tag_q} : {other_q[TAG_W], 1'b1, other_q[TAG_W-1:0]})
                      : hit ? {meta1[META_V], !hit_way, meta1[META_TAG_HI:0]} : '0;
        state_nx = miss ? FILL
                 : (data_wr_en && recv_cnt == CNT_W'(WORDS - 1)) ? META
                 : (state == META) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            issue_cnt <= '0;
            recv_cnt <= '0;
            issue_done <= 1'b0;
            victim_q <= 1'b0;
            tag_q <= '0;
            idx_q <= '0;
            other_q <= '0;
        end else begin
            state <= state_nx;
            if (miss) begin
                tag_q <= req_addr[15:8];
                idx_q <= req_addr[7:4];
                victim_q <= victim;
                other_q <= victim ? {meta0[META_V], meta0[META_TAG_HI:0]} : {meta1[META_V], meta1[META_TAG_HI:0]};
                issue_cnt <= '0;
                recv_cnt <= '0;
                issue_done <= 1'b0;
            end
            if (mem_rd_en) begin
                if (issue_cnt == CNT_W'(WORDS - 1))
                    issue_done <= 1'b1;
                else
                    issue_cnt <= issue_cnt + 1'b1;
            end
            if (data_wr_en)
                recv_cnt <= recv_cnt + 1'b1;
        end
    end
`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (miss && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;
    logic clk = 0, rst = 0, req_valid = 0, mem_data_valid = 0;
    logic [15:0] req_addr = 0;
    logic [9:0] meta0 = 0, meta1 = 0;
    logic hit, hit_way, stall, mem_rd_en, data_wr_en, data_wr_way;
    logic [15:0] mem_addr;
    logic [2:0] data_wr_word;
    logic [1:0] meta_wr_en;
    logic [9:0] meta_wr_data0, meta_wr_data1;
`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .meta0(meta0), .meta1(meta1), .hit(hit), .hit_way(hit_way), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
        .data_wr_en(data_wr_en), .data_wr_way(data_wr_way), .data_wr_word(data_wr_word),
        .meta_wr_en(meta_wr_en), .meta_wr_data0(meta_wr_data0), .meta_wr_data1(meta_wr_data1)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(); rst = 0; req_valid = 0; mem_data_valid = 0;
        cyc(); rst = 1;
    endtask

    task automatic test_reset();
        logic [61:0] outs;
        @(negedge clk);
        outs = {hit, hit_way, stall, mem_rd_en, mem_addr, data_wr_en, data_wr_way, data_wr_word, meta_wr_en, meta_wr_data0, meta_wr_data1};
        checks++; if (outs !== '0) $display("FAIL reset_outputs got %h exp 0", outs); else passed++;
        cyc(); rst = 1;
        @(negedge clk);
        outs = {hit, hit_way, stall, mem_rd_en, mem_addr, data_wr_en, data_wr_way, data_wr_word, meta_wr_en, meta_wr_data0, meta_wr_data1};
        checks++; if (outs !== '0) $display("FAIL post_reset_idle got %h exp 0", outs); else passed++;
    endtask

    task automatic test_cold_miss();
        logic v;
        cyc(); meta0 = 0; meta1 = 0; req_addr = 16'h3A46; req_valid = 1;
        @(negedge clk);
        checks++; if ({stall, hit, mem_rd_en} !== 3'b100) $display("FAIL cold_detect got %b exp 100", {stall, hit, mem_rd_en}); else passed++;
        for (int c = 0; c < 10; c++) begin
            v = (c >= 2);
            cyc(); mem_data_valid = v;
            @(negedge clk);
            checks++; if ({mem_rd_en, data_wr_en, stall, meta_wr_en} !== {c < 8, v, 1'b1, 2'b00})
                $display("FAIL cold_ctrl c=%0d got %b exp %b", c, {mem_rd_en, data_wr_en, stall, meta_wr_en}, {c < 8, v, 1'b1, 2'b00}); else passed++;
            if (c < 8) begin
                checks++; if (mem_addr !== 16'h3A40 + 16'(2 * c)) $display("FAIL cold_addr c=%0d got %h exp %h", c, mem_addr, 16'h3A40 + 16'(2 * c)); else passed++;
            end
            if (v) begin
                checks++; if ({data_wr_way, data_wr_word} !== {1'b0, 3'(c - 2)}) $display("FAIL cold_word c=%0d got %b exp %b", c, {data_wr_way, data_wr_word}, {1'b0, 3'(c - 2)}); else passed++;
            end
        end
        cyc(); mem_data_valid = 0;
        @(negedge clk);
        checks++; if ({stall, meta_wr_en, mem_rd_en} !== 4'b1110) $display("FAIL cold_meta_ctrl got %b exp 1110", {stall, meta_wr_en, mem_rd_en}); else passed++;
        checks++; if (meta_wr_data0 !== 10'h23A) $display("FAIL cold_meta0 got %h exp 23a", meta_wr_data0); else passed++;
        checks++; if (meta_wr_data1 !== 10'h100) $display("FAIL cold_meta1 got %h exp 100", meta_wr_data1); else passed++;
    endtask

    task automatic test_hit();
        cyc(); meta0 = 10'h23A; meta1 = 10'h100; req_addr = 16'h3A40; req_valid = 1;
        @(negedge clk);
        checks++; if ({hit, hit_way, stall, meta_wr_en} !== 5'b10011) $display("FAIL hit0_ctrl got %b exp 10011", {hit, hit_way, stall, meta_wr_en}); else passed++;
        checks++; if ({meta_wr_data0, meta_wr_data1} !== {10'h23A, 10'h100}) $display("FAIL hit0_meta got %h exp 23a/100", {meta_wr_data0, meta_wr_data1}); else passed++;
        cyc(); meta0 = 10'h211; meta1 = 10'h222; req_addr = 16'h2200;
        @(negedge clk);
        checks++; if ({hit, hit_way, stall, meta_wr_en} !== 5'b11011) $display("FAIL hit1_ctrl got %b exp 11011", {hit, hit_way, stall, meta_wr_en}); else passed++;
        checks++; if ({meta_wr_data0, meta_wr_data1} !== {10'h311, 10'h222}) $display("FAIL hit1_meta got %h exp 311/222", {meta_wr_data0, meta_wr_data1}); else passed++;
        cyc(); req_valid = 0;
        @(negedge clk);
        checks++; if ({hit, stall, meta_wr_en} !== 4'b0000) $display("FAIL no_req got %b exp 0000", {hit, stall, meta_wr_en}); else passed++;
    endtask

    task automatic test_lru_victim();
        cyc(); meta0 = 10'h211; meta1 = 10'h322; req_addr = 16'h3350; req_valid = 1;
        @(negedge clk);
        checks++; if ({stall, hit} !== 2'b10) $display("FAIL lru_detect got %b exp 10", {stall, hit}); else passed++;
        for (int c = 0; c < 8; c++) begin
            cyc(); mem_data_valid = 1;
            @(negedge clk);
            checks++; if ({data_wr_en, data_wr_way, data_wr_word, mem_addr} !== {1'b1, 1'b1, 3'(c), 16'h3350 + 16'(2 * c)})
                $display("FAIL lru_fill c=%0d got %h exp %h", c, {data_wr_en, data_wr_way, data_wr_word, mem_addr}, {1'b1, 1'b1, 3'(c), 16'h3350 + 16'(2 * c)}); else passed++;
        end
        cyc(); mem_data_valid = 0;
        @(negedge clk);
        checks++; if ({meta_wr_en, hit, stall} !== 4'b1101) $display("FAIL lru_meta_ctrl got %b exp 1101", {meta_wr_en, hit, stall}); else passed++;
        checks++; if ({meta_wr_data0, meta_wr_data1} !== {10'h311, 10'h233}) $display("FAIL lru_meta got %h exp 311/233", {meta_wr_data0, meta_wr_data1}); else passed++;
        cyc(); req_valid = 0;
    endtask

    task automatic test_mem_gaps();
        logic v;
        cyc(); meta0 = 10'h3AA; meta1 = 10'h3BB; req_addr = 16'h1270; req_valid = 1;
        @(negedge clk);
        checks++; if (stall !== 1'b1) $display("FAIL gap_detect got %b exp 1", stall); else passed++;
        for (int c = 0; c < 22; c++) begin
            v = (c % 3 == 0);
            cyc(); mem_data_valid = v;
            if (c == 10) req_valid = 0;
            @(negedge clk);
            checks++; if ({mem_rd_en, data_wr_en, stall, meta_wr_en} !== {c < 8, v, 1'b1, 2'b00})
                $display("FAIL gap_ctrl c=%0d got %b exp %b", c, {mem_rd_en, data_wr_en, stall, meta_wr_en}, {c < 8, v, 1'b1, 2'b00}); else passed++;
            if (v) begin
                checks++; if ({data_wr_way, data_wr_word} !== {1'b0, 3'(c / 3)}) $display("FAIL gap_word c=%0d got %b exp %b", c, {data_wr_way, data_wr_word}, {1'b0, 3'(c / 3)}); else passed++;
            end
        end
        cyc(); mem_data_valid = 0;
        @(negedge clk);
        checks++; if ({stall, meta_wr_en} !== 3'b111) $display("FAIL gap_meta_ctrl got %b exp 111", {stall, meta_wr_en}); else passed++;
        checks++; if ({meta_wr_data0, meta_wr_data1} !== {10'h212, 10'h3BB}) $display("FAIL gap_meta got %h exp 212/3bb", {meta_wr_data0, meta_wr_data1}); else passed++;
        cyc(); mem_data_valid = 1;
        @(negedge clk);
        checks++; if ({data_wr_en, stall} !== 2'b00) $display("FAIL gap_idle got %b exp 00", {data_wr_en, stall}); else passed++;
        mem_data_valid = 0;
    endtask

    task automatic test_reset_mid_fill();
        logic [61:0] outs;
        cyc(); meta0 = 0; meta1 = 0; req_addr = 16'h5A20; req_valid = 1;
        for (int c = 0; c < 4; c++) begin
            cyc(); mem_data_valid = 1;
        end
        @(negedge clk);
        checks++; if (data_wr_word !== 3'd3) $display("FAIL rst_pre_word got %0d exp 3", data_wr_word); else passed++;
        cyc(); rst = 0; req_valid = 0; mem_data_valid = 0;
        @(negedge clk);
        outs = {hit, hit_way, stall, mem_rd_en, mem_addr, data_wr_en, data_wr_way, data_wr_word, meta_wr_en, meta_wr_data0, meta_wr_data1};
        checks++; if (outs !== '0) $display("FAIL rst_mid_outputs got %h exp 0", outs); else passed++;
        cyc();
        @(negedge clk);
        checks++; if (meta_wr_en !== 2'b00) $display("FAIL rst_mid_meta got %b exp 00", meta_wr_en); else passed++;
        cyc(); rst = 1;
        @(negedge clk);
        checks++; if ({meta_wr_en, stall} !== 3'b000) $display("FAIL rst_release got %b exp 000", {meta_wr_en, stall}); else passed++;
        cyc(); req_valid = 1;
        @(negedge clk);
        checks++; if ({stall, hit} !== 2'b10) $display("FAIL rst_remiss got %b exp 10", {stall, hit}); else passed++;
        do_reset();
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            cyc(); req_valid = 0; mem_data_valid = 1;
            @(negedge clk);
            checks++; if ({data_wr_en, stall, meta_wr_en, mem_rd_en} !== 5'b0) $display("FAIL spurious c=%0d got %b exp 00000", c, {data_wr_en, stall, meta_wr_en, mem_rd_en}); else passed++;
        end
        cyc(); mem_data_valid = 0;
    endtask

`ifdef CACHE_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        @(negedge clk);
        checks++; if ({hit_cnt, miss_cnt} !== 32'h0) $display("FAIL perf_reset got %h exp 0", {hit_cnt, miss_cnt}); else passed++;
        cyc(); meta0 = 10'h23A; meta1 = 10'h100; req_addr = 16'h3A40; req_valid = 1;
        cyc(); cyc();
        cyc(); req_addr = 16'h7700;
        cyc(); req_valid = 0;
        @(negedge clk);
        checks++; if ({hit_cnt, miss_cnt} !== {16'd3, 16'd1}) $display("FAIL perf_counts got %0d/%0d exp 3/1", hit_cnt, miss_cnt); else passed++;
        do_reset();
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_lru_victim();
        test_mem_gaps();
        test_reset_mid_fill();
        test_spurious();
`ifdef CACHE_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Sits between the 2-way metadata arrays (32 blocks = 16 sets x 2 ways, 10-bit entries) and main memory.
- Consumes the metadata read for the addressed set, computes hit/way, and maintains the LRU bits.
- On a miss, fetches an 8-word (16-byte) block from memory, streams it into the data array, then writes the victim way's metadata.

Parameters:
- TAG_W, 8, tag bits (addr[15:8]).
- IDX_W, 4, set index bits (addr[7:4]).
- WORDS, 8, 16-bit words per block.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  cache access present this cycle; req_addr is held stable until stall drops.
- req_addr  in  16  byte address.
- meta0  in  10  way-0 metadata for set req_addr[7:4]; fields [9]=valid, [8]=lru, [7:0]=tag.
- meta1  in  10  way-1 metadata, same fields.
- hit  out  1  combinational: req_valid and a valid way tag-matches; forced 0 outside IDLE.
- hit_way  out  1  matching way (0 if none).
- stall  out  1  pipeline stall.
- mem_rd_en  out  1  memory read request.
- mem_addr  out  16  word-aligned read address.
- mem_data_valid  in  1  returned word valid (fixed-latency memory, in order).
- data_wr_en  out  1  data-array write strobe.
- data_wr_way  out  1  way being filled.
- data_wr_word  out  3  word offset being written; write data is mem_data, routed externally.
- meta_wr_en  out  2  per-way metadata write enable.
- meta_wr_data0  out  10  new way-0 metadata.
- meta_wr_data1  out  10  new way-1 metadata.

Behaviour:
- Reset: state IDLE; issue_cnt=0, recv_cnt=0; all outputs 0.
- States: IDLE, FILL, META.
- IDLE on hit:
  - meta_wr_en=2'b11 for one cycle (same cycle as hit).
  - Hit way gets lru=0; other way gets lru=1; tag and valid unchanged.
  - stall=0.
- IDLE on miss (req_valid & ~hit):
  - stall=1 combinationally.
  - Latch tag/index and the victim way; go to FILL.
  - Victim selection: way0 if invalid; else way1 if invalid; else the way with lru=1; if both lru bits are equal, way0.
- FILL issue:
  - mem_rd_en=1 for exactly 8 consecutive cycles.
  - mem_addr = {tag, idx, issue_cnt, 1'b0}; issue_cnt counts 0..7 and then holds.
- FILL receive:
  - Each mem_data_valid pulses data_wr_en with data_wr_word=recv_cnt, then recv_cnt++.
  - When the 8th word is received (recv_cnt=7 with valid), go to META.
- META (one cycle):
  - Victim gets {1, 0, latched tag}.
  - Other way gets its current valid/tag with lru=1.
  - meta_wr_en=2'b11; go to IDLE; stall=1 this cycle.
- The re-presented access hits on the next IDLE cycle.
- stall is 1 from the miss-detect cycle through META inclusive.
- mem_data_valid in IDLE or META is ignored.
- req_valid dropping mid-fill does not abort the fill.
- Reset mid-fill: immediate return to IDLE with no metadata write; the block stays as before (victim data may be partially overwritten, but its metadata is untouched).
- Counters are 3-bit and never wrap inside one fill.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Each counts IDLE hit cycles and miss entries respectively.
  - Each saturates at 16'hFFFF and clears on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - TAG_W, IDX_W, WORDS.
  - Metadata field positions (META_V=9, META_LRU=8, tag slice).
  - State enum {IDLE, FILL, META}.
- Sub-module cache_way_cmp (meta, tag -> match), instantiated once per way; FSM, counters and victim logic stay in the top.

Test Plan:
- Cold miss: after reset (meta0=meta1=0), req_addr=16'h3A46 -> stall=1; mem_rd_en for 8 cycles at 16'h3A40..16'h3A4E; after 8 valids, META writes meta0=10'h23A, meta1 lru=1.
- Hit: meta0=10'h23A, req_addr=16'h3A40 -> hit=1, hit_way=0, stall=0, meta_wr_en=2'b11, meta1[8]=1.
- LRU victim: both ways valid, meta0 lru=0, meta1 lru=1, tags 8'h11/8'h22, req tag 8'h33 -> fill goes to way1 (data_wr_way=1), meta_wr_data1=10'h233.
- Memory gaps: mem_data_valid pattern 1,0,0,1,... -> data_wr_word increments only on valid; META only after the 8th valid; stall held throughout.
- Reset at recv_cnt=4: all outputs 0 next cycle, meta_wr_en never asserted, same access misses again.
- Spurious mem_data_valid in IDLE -> no data_wr_en; with CACHE_PERF_CNT_EN, 3 hits + 1 miss -> hit_cnt=3, miss_cnt=1.
